// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the byte-serial memory arbiter.
// Sizes, FSM states, requester ids and the latched-request record live here.
package mem_arbiter_pkg;

  typedef logic [31:0] inst_addr_bus_t;
  typedef logic [31:0] inst_bus_t;

  localparam inst_bus_t ZeroWord = 32'h0000_0000;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    src_t        src;
    logic [2:0]  nbytes;
    logic [31:0] wdata;
  } req_t;

  // Encoding 11 is not defined by the MEM stage; it falls through to a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      SIZE_W:  size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: instruction fetch and MEM stage handshakes.
// master = pipeline side, slave = arbiter side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic           if_req;
  inst_addr_bus_t if_addr;
  logic           if_abort;
  logic           if_done;
  inst_bus_t      if_inst;

  logic           mem_req;
  logic           mem_we;
  logic [1:0]     mem_size;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic           mem_done;
  logic [31:0]    mem_rdata;

  modport master (
    output if_req, if_addr, if_abort, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  if_done, if_inst, mem_done, mem_rdata
  );

  modport slave (
    input  if_req, if_addr, if_abort, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output if_done, if_inst, mem_done, mem_rdata
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Winner select for the IDLE grant cycle plus the last_grant history bit.
// RR_FAIR_EN defined: ties alternate; undefined: MEM always wins a tie.
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic if_abort,
  input  logic mem_req,
  output logic grant,
  output src_t winner
);

`ifdef RR_FAIR_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  src_t last_grant;
  logic if_ok;

  // A fetch being intercepted in the grant cycle is not worth starting.
  assign if_ok = if_req & ~if_abort;
  assign grant = en & (mem_req | if_ok);

  always_comb begin
    winner = SRC_IF;
    if (mem_req && if_ok) begin
      winner = (Fair && last_grant == SRC_MEM) ? SRC_IF : SRC_MEM;
    end else if (mem_req) begin
      winner = SRC_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_IF;
    end else if (grant) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial single-port RAM controller shared by instruction fetch and MEM.
// Optional macro RR_FAIR_EN (in mem_arb_grant) makes tie-breaking alternate.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            state, state_nxt;
  req_t              req, req_nxt, sel_req;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [ADDR_W-1:0] addr, addr_nxt, cur_addr;
  logic [2:0]        cnt, cnt_nxt;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_q, asm_nxt;
  logic              read_last, abort_if;
  logic              grant;
  src_t              winner;

  logic [ADDR_W-1:0] ram_a_nxt;
  logic              ram_wr_nxt;
  logic [7:0]        ram_dout_nxt;
  logic              if_done_nxt, mem_done_nxt;
  logic [31:0]       if_inst_nxt, mem_rdata_nxt;

  mem_arb_grant u_grant (
    .clk      (clk),
    .rst      (rst),
    .en       (state == IDLE),
    .if_req   (bus.if_req),
    .if_abort (bus.if_abort),
    .mem_req  (bus.mem_req),
    .grant    (grant),
    .winner   (winner)
  );

  always_comb begin
    if (winner == SRC_MEM) begin
      sel_req  = '{src: SRC_MEM, nbytes: size_bytes(bus.mem_size), wdata: bus.mem_wdata};
      sel_we   = bus.mem_we;
      sel_addr = bus.mem_addr;
    end else begin
      sel_req  = '{src: SRC_IF, nbytes: 3'd4, wdata: ZeroWord};
      sel_we   = 1'b0;
      sel_addr = bus.if_addr;
    end
  end

  // cnt counts cycles since the grant: it equals the number of addresses issued
  // while issuing, and read data for byte cnt-2 is on ram_din.
  assign cur_addr  = addr + ADDR_W'(cnt);
  assign byte_idx  = 2'(cnt - 3'd2);
  assign read_last = (cnt == 3'(req.nbytes + 3'd1));
  assign abort_if  = (req.src == SRC_IF) && bus.if_abort;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = sel_we ? WRITE : READ;
      READ:    if (abort_if)       state_nxt = IDLE;
               else if (read_last) state_nxt = DONE;
      WRITE:   if (cnt >= req.nbytes) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    req_nxt       = req;
    addr_nxt      = addr;
    cnt_nxt       = cnt;
    asm_nxt       = asm_q;
    ram_a_nxt     = ram_a;
    ram_wr_nxt    = 1'b0;
    ram_dout_nxt  = ram_dout;
    if_done_nxt   = 1'b0;
    mem_done_nxt  = 1'b0;
    if_inst_nxt   = bus.if_inst;
    mem_rdata_nxt = bus.mem_rdata;
    unique case (state)
      IDLE: begin
        if (grant) begin
          req_nxt   = sel_req;
          addr_nxt  = ADDR_W'(sel_addr);
          cnt_nxt   = 3'd1;
          asm_nxt   = ZeroWord;
          ram_a_nxt = ADDR_W'(sel_addr);
          if (sel_we) begin
            ram_wr_nxt   = 1'b1;
            ram_dout_nxt = sel_req.wdata[7:0];
          end
        end
      end
      READ: begin
        if (!abort_if) begin
          if (cnt >= 3'd2) asm_nxt[{byte_idx, 3'b000} +: 8] = ram_din;
          if (cnt < req.nbytes) ram_a_nxt = cur_addr;
          cnt_nxt = cnt + 3'd1;
          if (read_last) begin
            if (req.src == SRC_MEM) begin
              mem_done_nxt  = 1'b1;
              mem_rdata_nxt = asm_nxt;
            end else begin
              if_done_nxt = 1'b1;
              if_inst_nxt = asm_nxt;
            end
          end
        end
      end
      WRITE: begin
        if (cnt < req.nbytes) begin
          ram_a_nxt    = cur_addr;
          ram_dout_nxt = req.wdata[{cnt[1:0], 3'b000} +: 8];
          ram_wr_nxt   = 1'b1;
          cnt_nxt      = cnt + 3'd1;
        end else begin
          mem_done_nxt = 1'b1;
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      req           <= '0;
      addr          <= '0;
      cnt           <= 3'd0;
      asm_q         <= ZeroWord;
      ram_a         <= '0;
      ram_wr        <= 1'b0;
      ram_dout      <= 8'h00;
      bus.if_done   <= 1'b0;
      bus.if_inst   <= ZeroWord;
      bus.mem_done  <= 1'b0;
      bus.mem_rdata <= ZeroWord;
    end else begin
      req           <= req_nxt;
      addr          <= addr_nxt;
      cnt           <= cnt_nxt;
      asm_q         <= asm_nxt;
      ram_a         <= ram_a_nxt;
      ram_wr        <= ram_wr_nxt;
      ram_dout      <= ram_dout_nxt;
      bus.if_done   <= if_done_nxt;
      bus.if_inst   <= if_inst_nxt;
      bus.mem_done  <= mem_done_nxt;
      bus.mem_rdata <= mem_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide registered-read RAM model.
// Tie expectations follow RR_FAIR_EN when it is defined for the build.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic [7:0]        ram [0:(1 << ADDR_W) - 1];

  int total = 0;
  int bad   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din)
  );

  always #5 clk = ~clk;

  // Read returns the pre-write contents one cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.if_abort  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ram_a, ram_wr, ram_dout} !== '0) begin
      bad++;
      $display("FAIL reset_ram: ram_a=%h ram_wr=%b ram_dout=%h, want all 0", ram_a, ram_wr, ram_dout);
    end
    total++;
    if ({bus.if_done, bus.if_inst, bus.mem_done, bus.mem_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_bus: if_done=%b if_inst=%h mem_done=%b mem_rdata=%h, want all 0",
               bus.if_done, bus.if_inst, bus.mem_done, bus.mem_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    bus.if_addr = 32'h0000_0010;
    bus.if_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        total++;
        if (ram_a !== 17'(32'h10 + k - 1) || ram_wr !== 1'b0) begin
          bad++;
          $display("FAIL fetch_addr G+%0d: ram_a=%h ram_wr=%b, want %h/0", k, ram_a, ram_wr, 17'(32'h10 + k - 1));
        end
      end
      total++;
      if (bus.if_done !== 1'(k == 6)) begin
        bad++;
        $display("FAIL fetch_done G+%0d: if_done=%b, want %b", k, bus.if_done, k == 6);
      end
    end
    total++;
    if (bus.if_inst !== 32'h0000_0513) begin
      bad++;
      $display("FAIL fetch_inst: got %h want 00000513", bus.if_inst);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.if_done !== 1'b0 || bus.if_inst !== 32'h0000_0513) begin
      bad++;
      $display("FAIL fetch_hold: if_done=%b if_inst=%h, want 0/00000513", bus.if_done, bus.if_inst);
    end
  endtask

  task automatic test_store();
    logic [31:0] wd = 32'hDEAD_BEEF;
    bus.mem_we    = 1'b1;
    bus.mem_size  = SIZE_W;
    bus.mem_addr  = 32'h0000_0100;
    bus.mem_wdata = wd;
    bus.mem_req   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 17'(32'h100 + k - 1) || ram_dout !== wd[8*(k-1) +: 8]) begin
          bad++;
          $display("FAIL store_beat G+%0d: wr=%b a=%h d=%h, want 1/%h/%h",
                   k, ram_wr, ram_a, ram_dout, 17'(32'h100 + k - 1), wd[8*(k-1) +: 8]);
        end
      end
      total++;
      if (bus.mem_done !== 1'(k == 5)) begin
        bad++;
        $display("FAIL store_done G+%0d: mem_done=%b, want %b", k, bus.mem_done, k == 5);
      end
    end
    total++;
    if (ram_wr !== 1'b0 || {ram[32'h103], ram[32'h102], ram[32'h101], ram[32'h100]} !== wd) begin
      bad++;
      $display("FAIL store_ram: ram_wr=%b word=%h, want 0/%h", ram_wr,
               {ram[32'h103], ram[32'h102], ram[32'h101], ram[32'h100]}, wd);
    end
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [31:0] la [3] = '{32'h100, 32'h102, 32'h100};
    logic [1:0]  ls [3] = '{SIZE_B, SIZE_H, 2'b11};
    int          ln [3] = '{1, 2, 4};
    logic [31:0] lx [3] = '{32'h0000_00EF, 32'h0000_DEAD, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      bus.mem_we   = 1'b0;
      bus.mem_size = ls[i];
      bus.mem_addr = la[i];
      bus.mem_req  = 1'b1;
      for (int k = 1; k <= ln[i] + 2; k++) begin
        @(negedge clk);
        if (k == 1) begin
          total++;
          if (ram_a !== 17'(la[i]) || ram_wr !== 1'b0) begin
            bad++;
            $display("FAIL load%0d_addr: ram_a=%h ram_wr=%b, want %h/0", i, ram_a, ram_wr, 17'(la[i]));
          end
        end
        total++;
        if (bus.mem_done !== 1'(k == ln[i] + 2)) begin
          bad++;
          $display("FAIL load%0d_done G+%0d: mem_done=%b, want %b", i, k, bus.mem_done, k == ln[i] + 2);
        end
      end
      total++;
      if (bus.mem_rdata !== lx[i] || bus.if_inst !== 32'h0000_0513) begin
        bad++;
        $display("FAIL load%0d_data: mem_rdata=%h if_inst=%h, want %h/00000513",
                 i, bus.mem_rdata, bus.if_inst, lx[i]);
      end
      bus.mem_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    bus.if_addr = 32'h0000_0020;
    bus.if_req  = 1'b1;
    @(negedge clk);
    total++;
    if (ram_a !== 17'h00020) begin
      bad++;
      $display("FAIL abort_first_addr: ram_a=%h want 00020", ram_a);
    end
    @(negedge clk);
    bus.if_abort = 1'b1;
    bus.if_addr  = 32'h0000_0040;
    @(negedge clk);
    bus.if_abort = 1'b0;
    total++;
    if (dut.state !== IDLE || bus.if_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: state=%0d if_done=%b, want IDLE/0", dut.state, bus.if_done);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (ram_a !== 17'h00040) begin
          bad++;
          $display("FAIL abort_refetch_addr: ram_a=%h want 00040", ram_a);
        end
      end
      total++;
      if (bus.if_done !== 1'(k == 6)) begin
        bad++;
        $display("FAIL abort_refetch_done G+%0d: if_done=%b, want %b", k, bus.if_done, k == 6);
      end
    end
    total++;
    if (bus.if_inst !== 32'h0010_0093) begin
      bad++;
      $display("FAIL abort_refetch_inst: got %h want 00100093", bus.if_inst);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] wa [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    bus.if_addr = 32'h0001_FFFE;
    bus.if_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        total++;
        if (ram_a !== wa[k-1]) begin
          bad++;
          $display("FAIL wrap_addr G+%0d: ram_a=%h want %h", k, ram_a, wa[k-1]);
        end
      end
    end
    total++;
    if (bus.if_done !== 1'b1 || bus.if_inst !== 32'h4433_2211) begin
      bad++;
      $display("FAIL wrap_inst: if_done=%b if_inst=%h, want 1/44332211", bus.if_done, bus.if_inst);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  // Both requesters raise together; the MEM load of 0x100 must go first.
  task automatic start_tie_mem_first(input string tag);
    bus.if_addr  = 32'h0000_0010;
    bus.if_req   = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = SIZE_W;
    bus.mem_addr = 32'h0000_0100;
    bus.mem_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (ram_a !== 17'h00100) begin
          bad++;
          $display("FAIL %s_mem_first: ram_a=%h want 00100", tag, ram_a);
        end
      end
      total++;
      if (bus.mem_done !== 1'(k == 6) || bus.if_done !== 1'b0) begin
        bad++;
        $display("FAIL %s_mem_done G+%0d: mem_done=%b if_done=%b, want %b/0", tag, k, bus.mem_done, bus.if_done, k == 6);
      end
    end
    total++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL %s_mem_data: got %h want deadbeef", tag, bus.mem_rdata);
    end
  endtask

  // Grant taken in the current IDLE negedge; checks address at G+1 and done at G+n+2.
  task automatic follow_read(input string tag, input bit is_mem, input logic [ADDR_W-1:0] a,
                             input int n, input logic [31:0] want);
    for (int j = 1; j <= n + 2; j++) begin
      @(negedge clk);
      if (j == 1) begin
        total++;
        if (ram_a !== a) begin
          bad++;
          $display("FAIL %s_addr: ram_a=%h want %h", tag, ram_a, a);
        end
      end
      total++;
      if ((is_mem ? bus.mem_done : bus.if_done) !== 1'(j == n + 2)
          || (is_mem ? bus.if_done : bus.mem_done) !== 1'b0) begin
        bad++;
        $display("FAIL %s_done G+%0d: if_done=%b mem_done=%b", tag, j, bus.if_done, bus.mem_done);
      end
    end
    total++;
    if ((is_mem ? bus.mem_rdata : bus.if_inst) !== want) begin
      bad++;
      $display("FAIL %s_data: got %h want %h", tag, is_mem ? bus.mem_rdata : bus.if_inst, want);
    end
  endtask

  task automatic test_tie_priority();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_tie_mem_first("tie1");
    bus.mem_req = 1'b0;
    @(negedge clk);
    follow_read("tie1_if_after", 1'b0, 17'h00010, 4, 32'h0000_0513);
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie_rr();
    start_tie_mem_first("tie2");
    bus.mem_addr = 32'h0000_0040;
    bus.mem_size = SIZE_B;
    @(negedge clk);
`ifdef RR_FAIR_EN
    follow_read("tie2_if_wins", 1'b0, 17'h00010, 4, 32'h0000_0513);
    bus.if_req = 1'b0;
    @(negedge clk);
    follow_read("tie2_mem_next", 1'b1, 17'h00040, 1, 32'h0000_0093);
    bus.mem_req = 1'b0;
`else
    follow_read("tie2_mem_wins", 1'b1, 17'h00040, 1, 32'h0000_0093);
    bus.mem_req = 1'b0;
    @(negedge clk);
    follow_read("tie2_if_next", 1'b0, 17'h00010, 4, 32'h0000_0513);
    bus.if_req = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int late_done = 0;
    bus.mem_we    = 1'b1;
    bus.mem_size  = SIZE_W;
    bus.mem_addr  = 32'h0000_0200;
    bus.mem_wdata = 32'h0102_0304;
    bus.mem_req   = 1'b1;
    @(negedge clk);
    total++;
    if (ram_wr !== 1'b1 || ram_a !== 17'h00200) begin
      bad++;
      $display("FAIL rstmid_start: ram_wr=%b ram_a=%h, want 1/00200", ram_wr, ram_a);
    end
    @(negedge clk);
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ram_a, ram_wr, ram_dout, bus.if_done, bus.if_inst, bus.mem_done, bus.mem_rdata} !== '0
        || dut.state !== IDLE) begin
      bad++;
      $display("FAIL rstmid_outputs: ram_a=%h ram_wr=%b mem_done=%b state=%0d, want 0/0/0/IDLE",
               ram_a, ram_wr, bus.mem_done, dut.state);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_done !== 1'b0 || ram_wr !== 1'b0) late_done++;
    end
    total++;
    if (late_done !== 0 || ram[32'h202] !== 8'h00 || ram[32'h200] !== 8'h04 || ram[32'h201] !== 8'h03) begin
      bad++;
      $display("FAIL rstmid_after: late_cycles=%0d ram200..202=%h %h %h, want 0 / 04 03 00",
               late_done, ram[32'h200], ram[32'h201], ram[32'h202]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
    {ram[32'h13], ram[32'h12], ram[32'h11], ram[32'h10]}         = 32'h0000_0513;
    {ram[32'h23], ram[32'h22], ram[32'h21], ram[32'h20]}         = 32'hDDCC_BBAA;
    {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]}         = 32'h0010_0093;
    {ram[32'h1], ram[32'h0], ram[32'h1FFFF], ram[32'h1FFFE]}     = 32'h4433_2211;

    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_abort();
    test_wrap();
    test_tie_priority();
    test_tie_rr();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port, byte-serial memory controller shared by instruction fetch (IF) and the MEM stage.
- Serializes 32-bit fetches and 1/2/4-byte loads/stores onto an 8-bit synchronous RAM bus.
- Returns assembled words with one-cycle done pulses to its requesters.
- IF may be aborted on branch interception; the IF/ID register buffers any word delivered while the pipeline is stalled.

Parameters:
- ADDR_W, 17, RAM address width; request addresses truncated to ADDR_W LSBs.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- if_req  in  1  fetch request, held until if_done or if_abort
- if_addr  in  32  fetch address
- if_abort  in  1  branch interception; cancels pending/in-flight fetch
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_size  in  2  00=byte, 01=half, 10=word; 11 treated as word
- mem_addr  in  32  load/store address
- mem_wdata  in  32  store data; low N bytes used
- mem_done  out  1  one-cycle pulse
- mem_rdata  out  32  load data, zero-extended (sign extension is done in MEM)
- ram_a  out  ADDR_W  RAM address
- ram_wr  out  1  RAM write enable
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; byte for address presented in cycle t is valid in cycle t+1

Behaviour:
- Reset: all outputs 0; FSM to IDLE; byte counter, latched request, assembly register 0.
- FSM states: IDLE, READ, WRITE, DONE. All outputs registered.
- IDLE, grant cycle G:
  - Latch winner's address, size and wdata; N = 1/2/4 bytes.
  - Default priority: MEM over IF.
  - If if_abort is high in G, IF is not eligible.
  - Load or fetch -> READ; store -> WRITE.
- READ:
  - ram_a = addr+k in cycles G+1..G+N, ram_wr=0.
  - ram_din sampled in G+2..G+N+1; byte k goes to bits [8k+7:8k].
  - Enter DONE after the last sample; done pulse in cycle G+N+2.
  - Latency: word 6 cycles, byte 3 cycles.
- WRITE:
  - ram_a = addr+k, ram_dout = wdata byte k, ram_wr=1 in G+1..G+N.
  - mem_done in G+N+1.
- DONE:
  - Exactly one of if_done/mem_done is high.
  - if_inst/mem_rdata hold their value until the next done of the same port.
  - Return to IDLE the next cycle. A requester must drop req in the cycle after its done, else it is re-granted.
- Address arithmetic is modulo 2^ADDR_W; addr+k wraps, e.g. 0x1FFFF+1 -> 0x00000.
- if_abort:
  - During an IF READ: stop issuing, discard partial data, no if_done, IDLE next cycle.
  - During a MEM transaction or in IDLE without a grant: no effect.
  - Never truncates a store.
- if_abort in the same cycle as an IF DONE: the pulse still fires; IF/ID discards it via its own flush.
- rst mid-transaction: immediate return to IDLE, ram_wr=0 next cycle, no done pulse.
- Simultaneous if_req and mem_req, default: MEM wins; IF is granted in the IDLE after MEM's DONE.

Optional Feature:
- RR_FAIR_EN defined: when both requests are pending in IDLE, the grant alternates. A last_grant bit records the last winner; the other requester wins. last_grant resets to IF, so MEM wins the first tie.
- Undefined: fixed MEM priority; IF can starve under back-to-back MEM requests.
- Single-requester timing is identical either way.

Decomposition:
- Shared defines: size encodings (SIZE_B/H/W), FSM state encodings, ZeroWord, InstAddrBus/InstBus.
- One natural sub-module, mem_arb_grant: combinational winner select plus last_grant register.
- FSM and byte datapath stay in mem_arbiter.

Test Plan:
- Reset, then IF fetch at 0x0000_0010 with RAM[0x10..0x13]=0x13,0x05,0x00,0x00:
  - ram_a 0x10..0x13 in G+1..G+4.
  - if_done in G+6 with if_inst=0x0000_0513.
  - All outputs 0 after rst.
- MEM store word 0xDEADBEEF to 0x100: ram_wr=1 with bytes EF,BE,AD,DE at 0x100..0x103 in G+1..G+4; mem_done in G+5.
- MEM load byte from 0x100 after that store: mem_rdata=0x0000_00EF, mem_done in G+3.
- if_req and mem_req both high in IDLE:
  - MEM granted first, IF granted after.
  - With RR_FAIR_EN and a second tie, IF wins.
- Fetch at 0x20, if_abort asserted at G+2:
  - No if_done.
  - IDLE at G+3.
  - New fetch at 0x40 granted and completes with correct data.
- Word fetch at address 0x1FFFE: ram_a sequence 1FFFE,1FFFF,00000,00001.
